// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared resolution, widths, types and fill FSM states
package vga_pkg;

  localparam int HD         = 1280;
  localparam int VD         = 1024;
  localparam int COORD_BITS = 11;
  localparam int COLOR_BITS = 2;
  localparam int CNT_BITS   = 21;

  typedef logic [COORD_BITS-1:0] coord_t;
  typedef logic [COLOR_BITS-1:0] color_t;
  typedef logic [CNT_BITS-1:0]   cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vga_rect_norm.sv
// rtl/vga_rect_norm.sv - corner normalisation, screen clipping and off-screen detection
module vga_rect_norm
  import vga_pkg::*;
(
  input  coord_t x0,
  input  coord_t y0,
  input  coord_t x1,
  input  coord_t y1,
  output coord_t xmin,
  output coord_t xmax,
  output coord_t ymin,
  output coord_t ymax,
  output logic   offscreen
);

  localparam coord_t X_LAST = coord_t'(HD - 1);
  localparam coord_t Y_LAST = coord_t'(VD - 1);

  coord_t xhi;
  coord_t yhi;

  always_comb begin
    xmin = (x0 < x1) ? x0 : x1;
    xhi  = (x0 < x1) ? x1 : x0;
    ymin = (y0 < y1) ? y0 : y1;
    yhi  = (y0 < y1) ? y1 : y0;
    // Only the far edge needs clipping; a near edge past the screen means nothing is drawn.
    xmax = (xhi > X_LAST) ? X_LAST : xhi;
    ymax = (yhi > Y_LAST) ? Y_LAST : yhi;
    offscreen = (xmin > X_LAST) || (ymin > Y_LAST);
  end

endmodule

// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - row-major rectangle fill engine driving the framebuffer write port
module vga_rect_fill
  import vga_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  input  logic [COORD_BITS-1:0] x0_i,
  input  logic [COORD_BITS-1:0] y0_i,
  input  logic [COORD_BITS-1:0] x1_i,
  input  logic [COORD_BITS-1:0] y1_i,
  input  logic [COLOR_BITS-1:0] color_i,
  input  logic                  ready_i,
  output logic [COORD_BITS-1:0] addr_x_o,
  output logic [COORD_BITS-1:0] addr_y_o,
  output logic [COLOR_BITS-1:0] color_o,
  output logic                  we_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_BITS-1:0]   pix_cnt_o
);

  fill_state_e state_q, state_d;

  coord_t n_xmin, n_xmax, n_ymin, n_ymax;
  logic   n_offscreen;
  coord_t xmin_q, xmax_q, ymax_q;
  logic   accept, xfer, row_end, last_px;

  vga_rect_norm u_norm (
    .x0        (x0_i),
    .y0        (y0_i),
    .x1        (x1_i),
    .y1        (y1_i),
    .xmin      (n_xmin),
    .xmax      (n_xmax),
    .ymin      (n_ymin),
    .ymax      (n_ymax),
    .offscreen (n_offscreen)
  );

  always_comb begin
    state_d = state_q;
    accept  = (state_q == IDLE) && start_i;
    xfer    = (state_q == FILL) && ready_i;
    row_end = (addr_x_o == xmax_q);
    last_px = row_end && (addr_y_o == ymax_q);
    case (state_q)
      IDLE:    if (start_i) state_d = n_offscreen ? DONE : FILL;
      FILL:    if (ready_i && last_px) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      addr_x_o  <= '0;
      addr_y_o  <= '0;
      color_o   <= '0;
      pix_cnt_o <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymax_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pix_cnt_o <= '0;
        // Address/colour stay untouched for an off-screen command since nothing is written.
        if (!n_offscreen) begin
          xmin_q   <= n_xmin;
          xmax_q   <= n_xmax;
          ymax_q   <= n_ymax;
          addr_x_o <= n_xmin;
          addr_y_o <= n_ymin;
          color_o  <= color_i;
        end
      end else if (xfer) begin
        pix_cnt_o <= pix_cnt_o + cnt_t'(1);
        if (!row_end) begin
          addr_x_o <= addr_x_o + coord_t'(1);
        end else if (!last_px) begin
          addr_x_o <= xmin_q;
          addr_y_o <= addr_y_o + coord_t'(1);
        end
      end
    end
  end

  assign we_o   = (state_q == FILL);
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb/tb_vga_rect_fill.sv - table-driven bench for the rectangle fill engine
module tb_vga_rect_fill;

  logic        clk, arstn, start, ready, we, busy, done;
  logic [10:0] x0, y0, x1, y1, ax, ay;
  logic [1:0]  col, col_o;
  logic [20:0] pix;

  int checks = 0;
  int errors = 0;

  vga_rect_fill dut (
    .clk_i     (clk),
    .arstn_i   (arstn),
    .start_i   (start),
    .x0_i      (x0),
    .y0_i      (y0),
    .x1_i      (x1),
    .y1_i      (y1),
    .color_i   (col),
    .ready_i   (ready),
    .addr_x_o  (ax),
    .addr_y_o  (ay),
    .color_o   (col_o),
    .we_o      (we),
    .busy_o    (busy),
    .done_o    (done),
    .pix_cnt_o (pix)
  );

  typedef struct {
    int x0, y0, x1, y1;
    int col;
    int n;
    int off;
    int poke;
    bit poke_done;
  } vec_t;

  vec_t vecs[10];
  int   exp_px[0:18];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, " we"}, 32'(we), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " addr_x"}, 32'(ax), 0);
    chk({nm, " addr_y"}, 32'(ay), 0);
    chk({nm, " color"}, 32'(col_o), 0);
    chk({nm, " pix_cnt"}, 32'(pix), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    @(negedge clk);
    x0 = 11'(v.x0); y0 = 11'(v.y0); x1 = 11'(v.x1); y1 = 11'(v.y1);
    col = 2'(v.col); ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Inputs change after the start edge; the latched command must be unaffected.
    x0 = 11'd0; y0 = 11'd0; x1 = 11'd1279; y1 = 11'd1023; col = ~2'(v.col);
    for (int i = 0; i < v.n; i++) begin
      nm = $sformatf("v%0d px%0d", idx, i);
      if (v.poke == i) start = 1'b1;
      chk({nm, " we"}, 32'(we), 1);
      chk({nm, " busy"}, 32'(busy), 1);
      chk({nm, " done"}, 32'(done), 0);
      chk({nm, " addr_x"}, 32'(ax), 32'(exp_px[v.off + i] / 4096));
      chk({nm, " addr_y"}, 32'(ay), 32'(exp_px[v.off + i] % 4096));
      chk({nm, " color"}, 32'(col_o), 32'(v.col));
      chk({nm, " pix_cnt"}, 32'(pix), 32'(i));
      @(negedge clk);
      start = 1'b0;
    end
    nm = $sformatf("v%0d end", idx);
    chk({nm, " done"}, 32'(done), 1);
    chk({nm, " busy"}, 32'(busy), 1);
    chk({nm, " we"}, 32'(we), 0);
    chk({nm, " pix_cnt"}, 32'(pix), 32'(v.n));
    if (v.poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nm = $sformatf("v%0d after", idx);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " we"}, 32'(we), 0);
    chk({nm, " pix_cnt"}, 32'(pix), 32'(v.n));
  endtask

  int bp_ready[7] = '{1, 0, 0, 1, 1, 0, 1};
  int bp_addr[7]  = '{0, 1, 1, 1, 2, 3, 3};

  initial begin
    exp_px = '{
      10*4096+20, 11*4096+20, 12*4096+20, 10*4096+21, 11*4096+21, 12*4096+21,
      1278*4096+1022, 1279*4096+1022, 1278*4096+1023, 1279*4096+1023,
      5*4096+5,
      7*4096+3, 7*4096+4, 7*4096+5,
      1279*4096+0,
      0*4096+9, 1*4096+9, 2*4096+9, 3*4096+9
    };
    vecs[0] = '{x0:10,   y0:20,   x1:12,   y1:21,   col:3, n:6, off:0,  poke:-1, poke_done:0};
    vecs[1] = '{x0:12,   y0:21,   x1:10,   y1:20,   col:3, n:6, off:0,  poke:-1, poke_done:0};
    vecs[2] = '{x0:1278, y0:1022, x1:1300, y1:1030, col:1, n:4, off:6,  poke:-1, poke_done:0};
    vecs[3] = '{x0:1280, y0:0,    x1:1290, y1:5,    col:2, n:0, off:0,  poke:-1, poke_done:0};
    vecs[4] = '{x0:5,    y0:5,    x1:5,    y1:5,    col:2, n:1, off:10, poke:-1, poke_done:0};
    vecs[5] = '{x0:7,    y0:5,    x1:7,    y1:3,    col:0, n:3, off:11, poke:-1, poke_done:0};
    vecs[6] = '{x0:0,    y0:1024, x1:3,    y1:1030, col:1, n:0, off:0,  poke:-1, poke_done:0};
    vecs[7] = '{x0:10,   y0:20,   x1:12,   y1:21,   col:2, n:6, off:0,  poke:2,  poke_done:1};
    vecs[8] = '{x0:1279, y0:0,    x1:1279, y1:0,    col:1, n:1, off:14, poke:-1, poke_done:0};
    vecs[9] = '{x0:3,    y0:9,    x1:0,    y1:9,    col:3, n:4, off:15, poke:-1, poke_done:1};

    arstn = 1'b0; start = 1'b0; ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; col = '0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    arstn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Backpressure on a 4-pixel row: address must hold while ready is low.
    @(negedge clk);
    x0 = 11'd0; y0 = 11'd0; x1 = 11'd3; y1 = 11'd0; col = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ready = bp_ready[k][0];
      chk($sformatf("bp%0d we", k), 32'(we), 1);
      chk($sformatf("bp%0d addr_x", k), 32'(ax), 32'(bp_addr[k]));
      chk($sformatf("bp%0d addr_y", k), 32'(ay), 0);
      chk($sformatf("bp%0d pix_cnt", k), 32'(pix), 32'(bp_addr[k]));
      chk($sformatf("bp%0d done", k), 32'(done), 0);
      @(negedge clk);
    end
    ready = 1'b1;
    chk("bp end done", 32'(done), 1);
    chk("bp end we", 32'(we), 0);
    chk("bp end pix_cnt", 32'(pix), 4);
    @(negedge clk);
    chk("bp after busy", 32'(busy), 0);

    // Reset in the middle of a long fill aborts it without a done pulse.
    x0 = 11'd0; y0 = 11'd0; x1 = 11'd100; y1 = 11'd0; col = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midfill addr_x", 32'(ax), 2);
    arstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle_zero($sformatf("rst%0d", k));
    end
    arstn = 1'b1;
    x0 = 11'd2; y0 = 11'd2; x1 = 11'd2; y1 = 11'd2; col = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart we", 32'(we), 1);
    chk("restart addr_x", 32'(ax), 2);
    chk("restart addr_y", 32'(ay), 2);
    chk("restart color", 32'(col_o), 1);
    chk("restart pix_cnt", 32'(pix), 0);
    @(negedge clk);
    chk("restart done", 32'(done), 1);
    chk("restart end pix_cnt", 32'(pix), 1);
    @(negedge clk);
    chk("restart after busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
